debug_loader: RTL and testbench

//  Host-side boot/debug controller sitting directly upstream of the core top.

---
 rtl/debug_loader_pkg.sv | 32 +++
 rtl/debug_loader_word_asm.sv | 30 +++
 rtl/debug_loader.sv | 214 +++++++++++++++++++++
 tb/tb_debug_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_loader_pkg.sv
// Shared opcodes, FSM state encoding and payload sizes for the debug loader.
// DEBUG_LOADER_CSUM_EN adds the checksum state used by the trailing-byte check.
package debug_loader_pkg;

    localparam logic [7:0] OP_IMEM_WR = 8'h01;
    localparam logic [7:0] OP_DMEM_WR = 8'h02;
    localparam logic [7:0] OP_REG_WR  = 8'h03;
    localparam logic [7:0] OP_BOOT    = 8'h04;
    localparam logic [7:0] OP_RUN     = 8'h05;
    localparam logic [7:0] OP_HALT    = 8'h06;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
`ifdef DEBUG_LOADER_CSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd3;
`endif
    localparam logic [2:0] ST_EXEC = 3'd4;

    function automatic logic [3:0] op_payload_bytes(input logic [7:0] op);
        case (op)
            OP_IMEM_WR, OP_DMEM_WR, OP_REG_WR: return 4'd8;
            OP_BOOT:                           return 4'd4;
            default:                           return 4'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op >= OP_IMEM_WR) && (op <= OP_HALT);
    endfunction

endpackage

// File: rtl/debug_loader_word_asm.sv
// Four-byte little-endian shift-in assembler; o_done flags the byte that completes the word.
module debug_loader_word_asm (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [31:0] o_word_nxt,
    output logic        o_done
);

    logic [31:0] r_word;
    logic [1:0]  r_count;

    // First byte ends up in bits 7:0 after four shifts.
    assign o_word_nxt = {i_byte, r_word[31:8]};
    assign o_word     = r_word;
    assign o_done     = i_shift && (r_count == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_word  <= o_word_nxt;
            r_count <= r_count + 2'd1;
        end
    end

endmodule

// File: rtl/debug_loader.sv
// Host byte-stream boot/debug loader driving core reset, boot address and debug write ports.
// Define DEBUG_LOADER_CSUM_EN to require a trailing 8-bit checksum byte on every command.
module debug_loader
    import debug_loader_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_core_rst,
    output logic [31:0] o_core_rst_addr,
    output logic        o_debug_imem_oe,
    output logic        o_debug_imem_we,
    output logic [31:0] o_debug_imem_addr,
    output logic [31:0] o_debug_imem_data,
    output logic        o_debug_dmem_oe,
    output logic        o_debug_dmem_we,
    output logic [31:0] o_debug_dmem_addr,
    output logic [31:0] o_debug_dmem_data,
    output logic        o_debug_reg_oe,
    output logic        o_debug_reg_we,
    output logic [4:0]  o_debug_reg_ra,
    output logic [4:0]  o_debug_reg_rb,
    output logic [31:0] o_debug_reg_data,
    output logic        o_cmd_done,
    output logic        o_err
);

`ifdef DEBUG_LOADER_CSUM_EN
    localparam bit         CSUM_EN = 1'b1;
    localparam logic [2:0] ST_TAIL = ST_CSUM;
`else
    localparam bit         CSUM_EN = 1'b0;
    localparam logic [2:0] ST_TAIL = ST_EXEC;
`endif

    logic [2:0]  r_state, w_state_nxt;
    logic [7:0]  r_op, w_op;
    logic        r_core_rst, r_exec_ok, r_err, r_cmd_done;
    logic [31:0] r_core_rst_addr;
    logic        r_imem_we, r_dmem_we, r_reg_we;
    logic [31:0] r_imem_addr, r_imem_data, r_dmem_addr, r_dmem_data, r_reg_data;
    logic [4:0]  r_reg_idx;
    logic        w_fire, w_last, w_bad_op, w_csum_ok, w_is_wr, w_misalign, w_cmd_err;
    logic        w_addr_done, w_data_done;
    logic [31:0] w_addr_word, w_addr_nxt, w_data_word, w_data_nxt, w_addr_fin, w_data_fin;

    assign o_in_ready = !i_rst && (r_state != ST_EXEC);
    assign w_fire     = i_in_valid && o_in_ready;
    assign w_op       = (r_state == ST_IDLE) ? i_in_data : r_op;

    debug_loader_word_asm u_addr_asm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_shift    (w_fire && (r_state == ST_ADDR)),
        .i_byte     (i_in_data),
        .o_word     (w_addr_word),
        .o_word_nxt (w_addr_nxt),
        .o_done     (w_addr_done)
    );

    debug_loader_word_asm u_data_asm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_shift    (w_fire && (r_state == ST_DATA)),
        .i_byte     (i_in_data),
        .o_word     (w_data_word),
        .o_word_nxt (w_data_nxt),
        .o_done     (w_data_done)
    );

`ifdef DEBUG_LOADER_CSUM_EN
    logic [7:0] r_sum;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (w_fire && (r_state == ST_IDLE)) begin
            r_sum <= i_in_data;
        end else if (w_fire) begin
            r_sum <= r_sum + i_in_data;
        end
    end
    assign w_csum_ok = (i_in_data == r_sum);
`else
    assign w_csum_ok = 1'b1;
`endif

    // w_last marks the byte that completes a command; the decision is taken on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        w_bad_op    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_fire) begin
                if (!op_known(i_in_data)) begin
                    w_bad_op = 1'b1;
                end else if (op_payload_bytes(i_in_data) == 4'd0) begin
                    w_state_nxt = ST_TAIL;
                    w_last      = !CSUM_EN;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: if (w_addr_done) begin
                if (op_payload_bytes(r_op) == 4'd4) begin
                    w_state_nxt = ST_TAIL;
                    w_last      = !CSUM_EN;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (w_data_done) begin
                w_state_nxt = ST_TAIL;
                w_last      = !CSUM_EN;
            end
`ifdef DEBUG_LOADER_CSUM_EN
            ST_CSUM: if (w_fire) begin
                w_state_nxt = ST_EXEC;
                w_last      = 1'b1;
            end
`endif
            ST_EXEC: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_addr_fin = (r_state == ST_ADDR) ? w_addr_nxt : w_addr_word;
    assign w_data_fin = (r_state == ST_DATA) ? w_data_nxt : w_data_word;
    assign w_is_wr    = op_payload_bytes(w_op) != 4'd0;
    assign w_misalign = ALIGN_CHECK && (w_op != OP_REG_WR) && (w_addr_fin[1:0] != 2'b00);
    assign w_cmd_err  = !w_csum_ok || (w_is_wr && (!r_core_rst || w_misalign));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_op            <= '0;
            r_core_rst      <= 1'b1;
            r_core_rst_addr <= RESET_VECTOR;
            r_exec_ok       <= 1'b0;
            r_err           <= 1'b0;
            r_cmd_done      <= 1'b0;
            r_imem_we       <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_reg_we        <= 1'b0;
            r_imem_addr     <= '0;
            r_imem_data     <= '0;
            r_dmem_addr     <= '0;
            r_dmem_data     <= '0;
            r_reg_idx       <= '0;
            r_reg_data      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_done <= w_bad_op || w_last;
            r_imem_we  <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_reg_we   <= 1'b0;
            if (w_fire && (r_state == ST_IDLE)) r_op <= i_in_data;
            if (w_bad_op || (w_last && w_cmd_err)) r_err <= 1'b1;
            if (w_last) r_exec_ok <= !w_cmd_err;
            if (w_last && !w_cmd_err) begin
                case (w_op)
                    OP_IMEM_WR: begin
                        r_imem_we   <= 1'b1;
                        r_imem_addr <= w_addr_fin;
                        r_imem_data <= w_data_fin;
                    end
                    OP_DMEM_WR: begin
                        r_dmem_we   <= 1'b1;
                        r_dmem_addr <= w_addr_fin;
                        r_dmem_data <= w_data_fin;
                    end
                    OP_REG_WR: if (w_addr_fin[4:0] != 5'd0) begin
                        r_reg_we   <= 1'b1;
                        r_reg_idx  <= w_addr_fin[4:0];
                        r_reg_data <= w_data_fin;
                    end
                    default: ;
                endcase
            end
            // Core-control side effects land at the end of EXEC; addr word is stable here.
            if ((r_state == ST_EXEC) && r_exec_ok) begin
                case (r_op)
                    OP_BOOT: r_core_rst_addr <= w_addr_word;
                    OP_RUN:  r_core_rst      <= 1'b0;
                    OP_HALT: r_core_rst      <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign o_core_rst        = r_core_rst;
    assign o_core_rst_addr   = r_core_rst_addr;
    assign o_debug_imem_oe   = r_core_rst;
    assign o_debug_imem_we   = r_imem_we;
    assign o_debug_imem_addr = r_imem_addr;
    assign o_debug_imem_data = r_imem_data;
    assign o_debug_dmem_oe   = r_core_rst;
    assign o_debug_dmem_we   = r_dmem_we;
    assign o_debug_dmem_addr = r_dmem_addr;
    assign o_debug_dmem_data = r_dmem_data;
    assign o_debug_reg_oe    = r_core_rst;
    assign o_debug_reg_we    = r_reg_we;
    assign o_debug_reg_ra    = r_reg_idx;
    assign o_debug_reg_rb    = r_reg_idx;
    assign o_debug_reg_data  = r_reg_data;
    assign o_cmd_done        = r_cmd_done;
    assign o_err             = r_err;

endmodule

// File: tb/tb_debug_loader.sv
// Randomized bench for debug_loader against a command-level reference model.
// Handles both builds: with DEBUG_LOADER_CSUM_EN every known command gets a checksum byte.
module tb_debug_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, core_rst, cmd_done, err;
    logic [31:0] core_rst_addr;
    logic        imem_oe, imem_we, dmem_oe, dmem_we, reg_oe, reg_we;
    logic [31:0] imem_addr, imem_data, dmem_addr, dmem_data, reg_data;
    logic [4:0]  reg_ra, reg_rb;

    debug_loader #(
        .RESET_VECTOR (32'h0000_0000),
        .ALIGN_CHECK  (1'b1)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_in_valid        (in_valid),
        .i_in_data         (in_data),
        .o_in_ready        (in_ready),
        .o_core_rst        (core_rst),
        .o_core_rst_addr   (core_rst_addr),
        .o_debug_imem_oe   (imem_oe),
        .o_debug_imem_we   (imem_we),
        .o_debug_imem_addr (imem_addr),
        .o_debug_imem_data (imem_data),
        .o_debug_dmem_oe   (dmem_oe),
        .o_debug_dmem_we   (dmem_we),
        .o_debug_dmem_addr (dmem_addr),
        .o_debug_dmem_data (dmem_data),
        .o_debug_reg_oe    (reg_oe),
        .o_debug_reg_we    (reg_we),
        .o_debug_reg_ra    (reg_ra),
        .o_debug_reg_rb    (reg_rb),
        .o_debug_reg_data  (reg_data),
        .o_cmd_done        (cmd_done),
        .o_err             (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic        m_core_rst = 1'b1;
    logic [31:0] m_boot = 32'h0;
    logic        m_err = 1'b0;
    logic [63:0] m_imem_last = '0, m_dmem_last = '0;
    logic [41:0] m_reg_last = '0;
    logic [63:0] exp_imem[$], exp_dmem[$], obs_imem[$], obs_dmem[$];
    logic [41:0] exp_reg[$], obs_reg[$];
    int exp_done = 0, obs_done = 0;
    int imem_seen = 0, dmem_seen = 0, reg_seen = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) obs_imem.push_back({imem_addr, imem_data});
        if (dmem_we === 1'b1) obs_dmem.push_back({dmem_addr, dmem_data});
        if (reg_we === 1'b1) obs_reg.push_back({reg_ra, reg_rb, reg_data});
        if (cmd_done === 1'b1) obs_done++;
    end

    task automatic model_cmd(input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input bit csum_ok);
        exp_done++;
        if (op == 8'd0 || op > 8'd6 || !csum_ok) begin
            m_err = 1'b1;
        end else if (op <= 8'd4 && (!m_core_rst || (op != 8'd3 && addr[1:0] != 2'b00))) begin
            m_err = 1'b1;
        end else begin
            case (op)
                8'd1: begin exp_imem.push_back({addr, data}); m_imem_last = {addr, data}; end
                8'd2: begin exp_dmem.push_back({addr, data}); m_dmem_last = {addr, data}; end
                8'd3: if (addr[4:0] != 5'd0) begin
                    exp_reg.push_back({addr[4:0], addr[4:0], data});
                    m_reg_last = {addr[4:0], addr[4:0], data};
                end
                8'd4: m_boot = addr;
                8'd5: m_core_rst = 1'b0;
                8'd6: m_core_rst = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) check("ready_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input int max_gap);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bytes.push_back(op);
        if (op >= 8'd1 && op <= 8'd4) for (int i = 0; i < 4; i++) bytes.push_back(8'(addr >> (8 * i)));
        if (op >= 8'd1 && op <= 8'd3) for (int i = 0; i < 4; i++) bytes.push_back(8'(data >> (8 * i)));
`ifdef DEBUG_LOADER_CSUM_EN
        if (op >= 8'd1 && op <= 8'd6) begin
            sum = 8'h00;
            foreach (bytes[i]) sum = sum + bytes[i];
            bytes.push_back(sum);
        end
`endif
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
        model_cmd(op, addr, data, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ready_in_rst", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        m_core_rst = 1'b1; m_boot = 32'h0; m_err = 1'b0;
        m_imem_last = '0; m_dmem_last = '0; m_reg_last = '0;
    endtask

    task automatic settle_check(input string tag);
        repeat (2) @(negedge clk);
        check({tag, ".core_rst"}, 64'(core_rst), 64'(m_core_rst));
        check({tag, ".rst_addr"}, 64'(core_rst_addr), 64'(m_boot));
        check({tag, ".err"}, 64'(err), 64'(m_err));
        check({tag, ".oe"}, 64'({imem_oe, dmem_oe, reg_oe}), 64'({3{m_core_rst}}));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        check({tag, ".imem_hold"}, {imem_addr, imem_data}, m_imem_last);
        check({tag, ".dmem_hold"}, {dmem_addr, dmem_data}, m_dmem_last);
        check({tag, ".reg_hold"}, 64'({reg_ra, reg_rb, reg_data}), 64'(m_reg_last));
        check({tag, ".done_cnt"}, 64'(obs_done), 64'(exp_done));
        check({tag, ".imem_n"}, 64'(obs_imem.size()), 64'(exp_imem.size()));
        check({tag, ".dmem_n"}, 64'(obs_dmem.size()), 64'(exp_dmem.size()));
        check({tag, ".reg_n"}, 64'(obs_reg.size()), 64'(exp_reg.size()));
        while (imem_seen < obs_imem.size() && imem_seen < exp_imem.size()) begin
            check({tag, ".imem_wr"}, obs_imem[imem_seen], exp_imem[imem_seen]);
            imem_seen++;
        end
        while (dmem_seen < obs_dmem.size() && dmem_seen < exp_dmem.size()) begin
            check({tag, ".dmem_wr"}, obs_dmem[dmem_seen], exp_dmem[dmem_seen]);
            dmem_seen++;
        end
        while (reg_seen < obs_reg.size() && reg_seen < exp_reg.size()) begin
            check({tag, ".reg_wr"}, 64'(obs_reg[reg_seen]), 64'(exp_reg[reg_seen]));
            reg_seen++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expired, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        logic [7:0]  op;
        logic [31:0] a, d;

        do_reset();
        settle_check("reset");

        // IMEM write with exact EXEC-cycle latency
        send_cmd(8'h01, 32'h0000_0000, 32'h0000_0513, 0);
        check("imem.we_exec", 64'(imem_we), 64'(1));
        check("imem.done_exec", 64'(cmd_done), 64'(1));
        check("imem.rdy_exec", 64'(in_ready), 64'(0));
        check("imem.ad_exec", {imem_addr, imem_data}, {32'h0, 32'h0000_0513});
        @(posedge clk);
        #1;
        check("imem.we_after", 64'(imem_we), 64'(0));
        check("imem.done_after", 64'(cmd_done), 64'(0));
        settle_check("imem");

        send_cmd(8'h04, 32'h0000_0100, 32'h0, 0);
        settle_check("boot");
        send_cmd(8'h05, 32'h0, 32'h0, 0);
        check("run.rst_exec", 64'(core_rst), 64'(1));
        @(posedge clk);
        #1;
        check("run.rst_after", 64'(core_rst), 64'(0));
        settle_check("run");
        send_cmd(8'h02, 32'h0000_0040, 32'h1234_5678, 0);
        settle_check("dmem_running");

        do_reset();
        send_cmd(8'h03, 32'h0000_0005, 32'hDEAD_BEEF, 0);
        check("reg.we_exec", 64'(reg_we), 64'(1));
        check("reg.ra_rb", 64'({reg_ra, reg_rb}), 64'({5'd5, 5'd5}));
        check("reg.data", 64'(reg_data), 64'(32'hDEAD_BEEF));
        settle_check("reg5");
        send_cmd(8'h03, 32'h0000_0000, 32'h1111_2222, 0);
        settle_check("reg0");

        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        do_reset();
        settle_check("midrst");
        send_cmd(8'h01, 32'h0000_0008, 32'hCAFE_F00D, 0);
        settle_check("after_midrst");

        send_cmd(8'h01, 32'h0000_0002, 32'h0000_0055, 0);
        settle_check("misalign");
        do_reset();
        send_cmd(8'h09, 32'h0, 32'h0, 0);
        settle_check("bad_op");

`ifdef DEBUG_LOADER_CSUM_EN
        do_reset();
        send_byte(8'h05, 0);
        send_byte(8'h05, 0);
        model_cmd(8'h05, 32'h0, 32'h0, 1'b1);
        settle_check("csum_ok");
        do_reset();
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        model_cmd(8'h05, 32'h0, 32'h0, 1'b0);
        settle_check("csum_bad");
`endif

        do_reset();
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 99);
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (r < 15)      op = 8'h01;
            else if (r < 30) op = 8'h02;
            else if (r < 45) op = 8'h03;
            else if (r < 55) op = 8'h04;
            else if (r < 68) op = 8'h05;
            else if (r < 85) op = 8'h06;
            else if (r < 92) op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(7, 255));
            else             op = 8'h00;
            if (op == 8'h03 && $urandom_range(0, 4) == 0) a[4:0] = 5'd0;
            if (r >= 92) begin
                do_reset();
                settle_check("rand_rst");
            end else begin
                send_cmd(op, a, d, 2);
                settle_check("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
